// File: rtl/tinker_loader.sv
// Boot-time program loader: parses a little-endian byte stream (word count, N words,
// XOR checksum), writes the words from the core reset PC upward and holds the core until done.
module tinker_loader #(
    parameter logic [63:0] BASE_ADDR = 64'h2000,
    parameter int unsigned MAX_WORDS = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_hold,
    output logic        done,
    output logic        err,
    output logic [31:0] words_loaded
);

    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_LOAD = 3'd1,
        ST_CSUM = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic [31:0] MAX_WORDS_C = 32'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  csum_q, csum_d;
    logic [31:0] words_loaded_q, words_loaded_d;
    logic        mem_we_q, mem_we_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        core_hold_q, core_hold_d;
    logic        in_ready_s;
    logic        accept_s;

    // Place a stream byte into lane idx of a little-endian 32-bit value.
    function automatic logic [31:0] insert_byte(input logic [31:0] val,
                                                input logic [1:0]  idx,
                                                input logic [7:0]  b);
        logic [31:0] r;
        r = val;
        case (idx)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            2'd3:    r[31:24] = b;
            default: r        = val;
        endcase
        return r;
    endfunction

    // Byte address of instruction word k.
    function automatic logic [63:0] word_addr(input logic [31:0] k);
        return BASE_ADDR + ({32'd0, k} << 2);
    endfunction

    // Byte acceptance handshake; a restart cycle never consumes a byte.
    always_comb begin
        in_ready_s = ((state_q == ST_HDR) || (state_q == ST_LOAD) || (state_q == ST_CSUM))
                     && !restart;
        accept_s   = in_valid && in_ready_s;
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d        = state_q;
        byte_idx_d     = byte_idx_q;
        cnt_d          = cnt_q;
        word_d         = word_q;
        csum_d         = csum_q;
        words_loaded_d = words_loaded_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;

        if (restart) begin
            state_d        = ST_HDR;
            byte_idx_d     = 2'd0;
            cnt_d          = 32'd0;
            word_d         = 32'd0;
            csum_d         = 8'd0;
            words_loaded_d = 32'd0;
        end else if (accept_s) begin
            case (state_q)
                ST_HDR: begin
                    cnt_d      = insert_byte(cnt_q, byte_idx_q, in_data);
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        if (cnt_d > MAX_WORDS_C) begin
                            state_d = ST_ERR;
                        end else if (cnt_d == 32'd0) begin
                            state_d = ST_CSUM;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end else begin
                        state_d = ST_HDR;
                    end
                end
                ST_LOAD: begin
                    word_d     = insert_byte(word_q, byte_idx_q, in_data);
                    csum_d     = csum_q ^ in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        mem_we_d       = 1'b1;
                        mem_addr_d     = word_addr(words_loaded_q);
                        mem_wdata_d    = word_d;
                        words_loaded_d = words_loaded_q + 32'd1;
                        // cnt_q is nonzero here, so the equality marks word N-1
                        if (words_loaded_d == cnt_q) begin
                            state_d = ST_CSUM;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_CSUM: begin
                    if (in_data == csum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        done_d      = (state_d == ST_DONE);
        err_d       = (state_d == ST_ERR);
        core_hold_d = (state_d != ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_HDR;
            byte_idx_q     <= 2'd0;
            cnt_q          <= 32'd0;
            word_q         <= 32'd0;
            csum_q         <= 8'd0;
            words_loaded_q <= 32'd0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= 64'd0;
            mem_wdata_q    <= 32'd0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            core_hold_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            byte_idx_q     <= byte_idx_d;
            cnt_q          <= cnt_d;
            word_q         <= word_d;
            csum_q         <= csum_d;
            words_loaded_q <= words_loaded_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            done_q         <= done_d;
            err_q          <= err_d;
            core_hold_q    <= core_hold_d;
        end
    end

    assign in_ready     = in_ready_s;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign core_hold    = core_hold_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: doc/tinker_loader.md
# tinker_loader

Boot-time program loader for the tinker core: it writes instruction words into unified memory, and the core's fetch stage then reads them. It accepts a little-endian byte stream on a valid/ready port and parses a 4-byte word-count header, N instruction words and a 1-byte XOR checksum. Each assembled word is written to memory starting at the core's reset PC. The loader holds the core in reset until a load completes with a good checksum.

## Interface
- BASE_ADDR, 64'h2000: byte address of the first instruction word (the core reset PC).
- MAX_WORDS, 16384: largest legal word count N.
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high.
- restart  input  1  one-cycle pulse; aborts or re-arms and returns to HDR.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  memory write strobe, one cycle per word.
- mem_addr  output  64  byte address of the write.
- mem_wdata  output  32  instruction word, little-endian assembled.
- core_hold  output  1  drive to the core's reset; 1 while not DONE.
- done  output  1  load complete and checksum matched.
- err  output  1  checksum mismatch or N > MAX_WORDS.
- words_loaded  output  32  count of words written so far.

## Operation
- Transfer rule: a byte is accepted at a posedge where in_valid && in_ready.
- in_ready = 1 in HDR, LOAD and CSUM; 0 in DONE and ERR.
- HDR state:
  - Accept 4 bytes, LSB first, into cnt[31:0].
  - On the 4th byte: if cnt > MAX_WORDS, go to ERR.
  - Else if cnt == 0, go to CSUM.
  - Else go to LOAD.
- LOAD state:
  - Collect bytes into a 32-bit word: byte 0 goes to [7:0], byte 3 goes to [31:24].
  - On the 4th byte of word k, register mem_we=1, mem_addr=BASE_ADDR+4*k and mem_wdata=word, then increment words_loaded.
  - After word N-1, go to CSUM.
- Running checksum: XOR of every LOAD byte. Header bytes are excluded. The checksum is cleared on entry to HDR.
- CSUM state: accept 1 byte.
  - If the byte equals the running checksum, go to DONE.
  - Otherwise go to ERR.
- DONE state: done=1, core_hold=0, stays until restart or reset.
- ERR state: err=1, core_hold=1, stays until restart or reset.
- restart, in any state:
  - Next state is HDR.
  - Clear the byte index, partial word, checksum, words_loaded, done and err.
  - core_hold=1.
  - Any byte offered in the restart cycle is not accepted (in_ready is forced to 0 that cycle).
- Address arithmetic is 64-bit unsigned: BASE_ADDR + (k<<2). No wrap within the legal N range.
- words_loaded is not cleared when a load ends in ERR, so it still shows the last written count.

## Timing
- Reset values: in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, core_hold=1, done=0, err=0, words_loaded=0, state=HDR.
- All outputs are registered. in_ready is combinational from state && !restart.
- Write latency: when the 4th byte of a word is accepted at edge t, mem_we is high during cycle t+1, for exactly one cycle. mem_addr and mem_wdata are valid in that same cycle.
- Throughput: one byte per cycle, so one word write per 4 cycles at most. The memory has no backpressure.
- Checksum byte accepted at edge t: done or err rises in cycle t+1. core_hold falls in cycle t+1 on success.
- The last word's mem_we (cycle t_w+1) always precedes done, because the checksum byte arrives at t_w+1 at the earliest.
- Asynchronous reset mid-load: everything returns to its reset value immediately. A pending mem_we is dropped. Memory contents already written are left as they are.
- in_valid low stalls parsing indefinitely; there is no timeout.

## Test plan
- Good load:
  - Stream 02 00 00 00, 11 22 33 44, AA BB CC DD, then checksum 0x44.
  - mem_we pulses twice: 0x2000 <- 0x44332211 and 0x2004 <- 0xDDCCBBAA.
  - Then done=1, core_hold=0, words_loaded=2.
- Bad checksum: same stream with checksum 0x45 -> err=1, core_hold=1, done=0, in_ready=0, words_loaded=2.
- Oversize and empty headers:
  - Header 0x00004001 (MAX_WORDS+1) -> err=1 one cycle after the 4th header byte, with no mem_we.
  - Header 0 followed by checksum 0x00 -> done=1 with no mem_we.
- Gapped stream: drop in_valid for random 0-5 cycle gaps between bytes of the good load -> identical writes, order and final state.
- Restart mid-word:
  - After the header plus 2 payload bytes, pulse restart. in_ready is 0 in that cycle.
  - Then send the full good load -> exactly 2 writes at 0x2000/0x2004, done=1.
- Async reset mid-load:
  - Assert reset during the 3rd byte of word 1 -> all outputs return to reset values, with no mem_we.
  - After reset is released, a full good load succeeds.
